thor2024_macro_expander: RTL and testbench
==========================================

# thor2024_macro_expander

Expands Thor2024 macro instructions (ENTER, LEAVE, PUSH, POP) into sequences of simple micro-ops and passes all other instructions through unchanged. Sits between the decode stage, which flags macro instructions, and the rename/queue stage. Valid/ready handshakes on both sides; one micro-op issued per cycle at most.

## Interface
- `SP_REG`, 31: stack-pointer register number.
- `FP_REG`, 30: frame-pointer register number.
- `LR_REG`, 29: link-register number.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  instruction accepted when `in_valid & in_ready`.
- `in_instr`  in  40  instruction word; opcode `[6:0]`.
- `in_pc`  in  32  instruction address.
- `out_valid`  out  1  micro-op valid.
- `out_ready`  in  1  downstream accepts micro-op.
- `out_kind`  out  2  0 PASS, 1 ADDI, 2 STORE, 3 LOAD.
- `out_rt`  out  6  destination (ADDI/LOAD) or store-data register.
- `out_ra`  out  6  base/source register.
- `out_imm`  out  24  two's-complement immediate/offset.
- `out_instr`  out  40  original instruction, for every micro-op.
- `out_pc`  out  32  PC of originating instruction.
- `out_idx`  out  3  micro-op index within sequence, from 0.
- `out_last`  out  1  final micro-op of sequence.

## Operation
- Field decode: PUSH/POP count n = `in_instr[34:33]`+1 (1..4); registers R1..R4 = `[12:7]`,`[18:13]`,`[24:19]`,`[30:25]`. ENTER frame size F = `in_instr[39:23]`, 17-bit unsigned, zero-extended to 24 bits.
- PUSH: ADDI sp,sp,-8n; then STORE Ri,[sp+8(i-1)] for i=1..n. n+1 uops.
- POP: LOAD Ri,[sp+8(i-1)] for i=1..n; then ADDI sp,sp,+8n. n+1 uops.
- ENTER: ADDI sp,sp,-16; STORE fp,[sp+0]; STORE lr,[sp+8]; ADDI fp,sp,0; ADDI sp,sp,-F. 5 uops.
- LEAVE: ADDI sp,fp,0; LOAD fp,[sp+0]; LOAD lr,[sp+8]; ADDI sp,sp,+16. 4 uops.
- Any other opcode: one PASS uop, `out_rt`/`out_ra`/`out_imm` = 0, `out_last`=1.
- "sp","fp","lr" mean `SP_REG`,`FP_REG`,`LR_REG`. For ADDI, `out_rt`=dest, `out_ra`=source.
- States: IDLE, EXPAND.
  - IDLE: `in_ready` = `!out_valid | out_ready`. On accept: latch instr/pc, present uop 0 next cycle. If sequence length >1, go to EXPAND.
  - EXPAND: `in_ready`=0. On each output handshake advance `out_idx`. When the uop with `out_idx` = length-2 handshakes, the last uop is presented next cycle and state returns to IDLE, so `in_ready` = `out_ready` during the last uop.
- Output registers stable while `out_valid & !out_ready`.
- `flush`: next cycle `out_valid`=0, state IDLE, `out_idx`=0; any instruction offered in the flush cycle is not accepted (`in_ready`=0 while `flush`=1). Flush overrides all other events.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, `out_valid`=0, `out_kind`/`out_rt`/`out_ra`/`out_imm`/`out_instr`/`out_pc`/`out_idx`/`out_last`=0; `in_ready`=1 after release. Reset mid-sequence abandons it.
- Latency: accepted instruction to `out_valid` = 1 cycle.
- Non-macro throughput 1/cycle with `out_ready` held high; macro of length L occupies L cycles minimum, next instruction accepted in the cycle its last uop is first presented.
- `out_imm` negative values sign-correct in 24 bits (e.g. -32 = 0xFFFFE0).

## Test plan
- Reset, then three back-to-back non-macro instrs with `out_ready`=1 -> three PASS uops on consecutive cycles, each `out_last`=1, `out_idx`=0, latency 1.
- PUSH n=3 (R1=5,R2=6,R3=7) -> ADDI 31,31,imm 0xFFFFE8; STORE 5,[31+0]; STORE 6,[31+8]; STORE 7,[31+16] with last=1 on idx 3.
- ENTER F=0x100 with `out_ready` toggling 1/0 each cycle -> 5 uops in order, fields stable during stalls, final ADDI 31,31,0xFFFF00.
- LEAVE followed immediately by POP n=1 (R1=3) -> 4 LEAVE uops, then LOAD 3,[31+0]; ADDI 31,31,+8; POP accepted on LEAVE's last-uop cycle, no bubble.
- `flush` asserted during ENTER idx 2 -> `out_valid`=0 next cycle, `in_ready`=1 the cycle after; new instr emits from idx 0.
- `rst_n` low during PUSH idx 1 -> all outputs 0 immediately; after release new PASS instr emits normally.

Source files
------------

// File: rtl/thor2024_macro_expander.sv
// Thor2024 macro expander: splits ENTER/LEAVE/PUSH/POP into ADDI/STORE/LOAD micro-ops,
// passes every other instruction through as a single PASS micro-op.
module thor2024_macro_expander #(
  parameter logic [5:0] SP_REG   = 6'd31,
  parameter logic [5:0] FP_REG   = 6'd30,
  parameter logic [5:0] LR_REG   = 6'd29,
  parameter logic [6:0] OP_ENTER = 7'h50,
  parameter logic [6:0] OP_LEAVE = 7'h51,
  parameter logic [6:0] OP_PUSH  = 7'h52,
  parameter logic [6:0] OP_POP   = 7'h53
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [5:0]  out_rt,
  output logic [5:0]  out_ra,
  output logic [23:0] out_imm,
  output logic [39:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  out_idx,
  output logic        out_last
);

  localparam logic [1:0] K_PASS  = 2'd0;
  localparam logic [1:0] K_ADDI  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_LOAD  = 2'd3;

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  typedef struct packed {
    logic [1:0]         kind;
    logic [5:0]         rt;
    logic [5:0]         ra;
    logic signed [23:0] imm;
    logic               last;
  } uop_t;

  function automatic logic [5:0] list_reg(input logic [39:0] ins, input logic [1:0] k);
    case (k)
      2'd0:    return ins[12:7];
      2'd1:    return ins[18:13];
      2'd2:    return ins[24:19];
      default: return ins[30:25];
    endcase
  endfunction

  // Micro-op number idx of the sequence for instruction ins; last flags the final one.
  function automatic uop_t gen_uop(input logic [39:0] ins, input logic [2:0] idx);
    uop_t               u;
    logic [2:0]         n;
    logic [2:0]         len;
    logic [2:0]         im1;
    logic signed [23:0] n8;
    logic signed [23:0] i8;
    logic signed [23:0] im1_8;
    logic signed [23:0] fsz;
    n     = 3'({1'b0, ins[34:33]} + 3'd1);
    im1   = idx - 3'd1;
    n8    = {18'd0, n, 3'b000};
    i8    = {18'd0, idx, 3'b000};
    im1_8 = {18'd0, im1, 3'b000};
    fsz   = {7'd0, ins[39:23]};
    u     = '0;
    len   = 3'd1;
    case (ins[6:0])
      OP_PUSH: begin
        len = n + 3'd1;
        if (idx == 3'd0) begin
          u.kind = K_ADDI; u.rt = SP_REG; u.ra = SP_REG; u.imm = -n8;
        end else begin
          u.kind = K_STORE; u.rt = list_reg(ins, im1[1:0]); u.ra = SP_REG; u.imm = im1_8;
        end
      end
      OP_POP: begin
        len = n + 3'd1;
        if (idx == n) begin
          u.kind = K_ADDI; u.rt = SP_REG; u.ra = SP_REG; u.imm = n8;
        end else begin
          u.kind = K_LOAD; u.rt = list_reg(ins, idx[1:0]); u.ra = SP_REG; u.imm = i8;
        end
      end
      OP_ENTER: begin
        len = 3'd5;
        case (idx)
          3'd0:    begin u.kind = K_ADDI;  u.rt = SP_REG; u.ra = SP_REG; u.imm = -24'sd16; end
          3'd1:    begin u.kind = K_STORE; u.rt = FP_REG; u.ra = SP_REG; u.imm = 24'sd0;   end
          3'd2:    begin u.kind = K_STORE; u.rt = LR_REG; u.ra = SP_REG; u.imm = 24'sd8;   end
          3'd3:    begin u.kind = K_ADDI;  u.rt = FP_REG; u.ra = SP_REG; u.imm = 24'sd0;   end
          default: begin u.kind = K_ADDI;  u.rt = SP_REG; u.ra = SP_REG; u.imm = -fsz;     end
        endcase
      end
      OP_LEAVE: begin
        len = 3'd4;
        case (idx)
          3'd0:    begin u.kind = K_ADDI; u.rt = SP_REG; u.ra = FP_REG; u.imm = 24'sd0;  end
          3'd1:    begin u.kind = K_LOAD; u.rt = FP_REG; u.ra = SP_REG; u.imm = 24'sd0;  end
          3'd2:    begin u.kind = K_LOAD; u.rt = LR_REG; u.ra = SP_REG; u.imm = 24'sd8;  end
          default: begin u.kind = K_ADDI; u.rt = SP_REG; u.ra = SP_REG; u.imm = 24'sd16; end
        endcase
      end
      default: u.kind = K_PASS;
    endcase
    u.last = (idx == len - 3'd1);
    return u;
  endfunction

  state_t             state_q;
  logic               out_valid_q;
  logic [1:0]         kind_q;
  logic [5:0]         rt_q;
  logic [5:0]         ra_q;
  logic signed [23:0] imm_q;
  logic [39:0]        instr_q;
  logic [31:0]        pc_q;
  logic [2:0]         idx_q;
  logic               last_q;

  logic       accept;
  logic [2:0] idx_d;
  uop_t       acc_uop_d;
  uop_t       adv_uop_d;

  assign in_ready  = !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign idx_d     = idx_q + 3'd1;
  assign acc_uop_d = gen_uop(in_instr, 3'd0);
  assign adv_uop_d = gen_uop(instr_q, idx_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      kind_q      <= '0;
      rt_q        <= '0;
      ra_q        <= '0;
      imm_q       <= '0;
      instr_q     <= '0;
      pc_q        <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            kind_q      <= acc_uop_d.kind;
            rt_q        <= acc_uop_d.rt;
            ra_q        <= acc_uop_d.ra;
            imm_q       <= acc_uop_d.imm;
            last_q      <= acc_uop_d.last;
            instr_q     <= in_instr;
            pc_q        <= in_pc;
            idx_q       <= '0;
            state_q     <= acc_uop_d.last ? S_IDLE : S_EXPAND;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          // out_valid is always set while expanding; advance only on a handshake
          if (out_ready) begin
            kind_q  <= adv_uop_d.kind;
            rt_q    <= adv_uop_d.rt;
            ra_q    <= adv_uop_d.ra;
            imm_q   <= adv_uop_d.imm;
            last_q  <= adv_uop_d.last;
            idx_q   <= idx_d;
            state_q <= adv_uop_d.last ? S_IDLE : S_EXPAND;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = kind_q;
  assign out_rt    = rt_q;
  assign out_ra    = ra_q;
  assign out_imm   = imm_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_thor2024_macro_expander.sv
// Directed bench for thor2024_macro_expander: hand-computed micro-op sequences,
// stalls, back-to-back macros, flush and mid-sequence reset.
module tb_thor2024_macro_expander;

  localparam logic [6:0] OP_ENTER = 7'h50;
  localparam logic [6:0] OP_LEAVE = 7'h51;
  localparam logic [6:0] OP_PUSH  = 7'h52;
  localparam logic [6:0] OP_POP   = 7'h53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_kind;
  logic [5:0]  out_rt;
  logic [5:0]  out_ra;
  logic [23:0] out_imm;
  logic [39:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_idx;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  thor2024_macro_expander #(
    .SP_REG(6'd31), .FP_REG(6'd30), .LR_REG(6'd29),
    .OP_ENTER(OP_ENTER), .OP_LEAVE(OP_LEAVE), .OP_PUSH(OP_PUSH), .OP_POP(OP_POP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_rt(out_rt), .out_ra(out_ra), .out_imm(out_imm), .out_instr(out_instr),
    .out_pc(out_pc), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_uop(input string tag, input logic [1:0] kind, input logic [5:0] rt,
                           input logic [5:0] ra, input logic [23:0] imm, input logic [2:0] idx,
                           input logic last, input logic [39:0] instr, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".kind"},  64'(out_kind),  64'(kind));
    check({tag, ".rt"},    64'(out_rt),    64'(rt));
    check({tag, ".ra"},    64'(out_ra),    64'(ra));
    check({tag, ".imm"},   64'(out_imm),   64'(imm));
    check({tag, ".idx"},   64'(out_idx),   64'(idx));
    check({tag, ".last"},  64'(out_last),  64'(last));
    check({tag, ".instr"}, 64'(out_instr), 64'(instr));
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".kind"},  64'(out_kind),  64'd0);
    check({tag, ".rt"},    64'(out_rt),    64'd0);
    check({tag, ".ra"},    64'(out_ra),    64'd0);
    check({tag, ".imm"},   64'(out_imm),   64'd0);
    check({tag, ".instr"}, 64'(out_instr), 64'd0);
    check({tag, ".pc"},    64'(out_pc),    64'd0);
    check({tag, ".idx"},   64'(out_idx),   64'd0);
    check({tag, ".last"},  64'(out_last),  64'd0);
  endtask

  function automatic logic [39:0] mk_list(input logic [6:0] op, input logic [1:0] nm1,
                                          input logic [5:0] r1, input logic [5:0] r2,
                                          input logic [5:0] r3, input logic [5:0] r4);
    logic [39:0] ins;
    ins = '0;
    ins[6:0] = op;
    ins[12:7] = r1;
    ins[18:13] = r2;
    ins[24:19] = r3;
    ins[30:25] = r4;
    ins[34:33] = nm1;
    return ins;
  endfunction

  function automatic logic [39:0] mk_enter(input logic [16:0] f);
    logic [39:0] ins;
    ins = '0;
    ins[6:0] = OP_ENTER;
    ins[39:23] = f;
    return ins;
  endfunction

  localparam logic [1:0] PASS = 2'd0, ADDI = 2'd1, STORE = 2'd2, LOAD = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  rt;
    logic [5:0]  ra;
    logic [23:0] imm;
  } exp_t;

  initial begin
    logic [39:0] p1, p2, p3, p4, p5, push3, enter, leave, pop1, enter2, push2;
    exp_t enter_exp [5];
    p1 = 40'h00_1234_5613;
    p2 = 40'hFF_FFFF_FF01;
    p3 = 40'h80_0000_0037;
    p4 = 40'h12_0000_0063;
    p5 = 40'h00_0000_0033;
    push3  = mk_list(OP_PUSH, 2'd2, 6'd5, 6'd6, 6'd7, 6'd0);
    pop1   = mk_list(OP_POP, 2'd0, 6'd3, 6'd0, 6'd0, 6'd0);
    push2  = mk_list(OP_PUSH, 2'd1, 6'd1, 6'd2, 6'd0, 6'd0);
    enter  = mk_enter(17'h100);
    enter2 = mk_enter(17'h10);
    leave  = '0;
    leave[6:0] = OP_LEAVE;
    enter_exp[0] = '{ADDI,  6'd31, 6'd31, 24'hFFFFF0};
    enter_exp[1] = '{STORE, 6'd30, 6'd31, 24'h000000};
    enter_exp[2] = '{STORE, 6'd29, 6'd31, 24'h000008};
    enter_exp[3] = '{ADDI,  6'd30, 6'd31, 24'h000000};
    enter_exp[4] = '{ADDI,  6'd31, 6'd31, 24'hFFFF00};

    // Reset state
    tick(); tick();
    check_zero("reset");
    rst_n = 1'b1;
    #1 check("reset.in_ready", 64'(in_ready), 64'd1);

    // Three back-to-back PASS instructions
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = p1; in_pc = 32'h100;
    tick();
    check_uop("pass1", PASS, 0, 0, 0, 0, 1, p1, 32'h100);
    in_instr = p2; in_pc = 32'h104;
    #1 check("pass1.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_uop("pass2", PASS, 0, 0, 0, 0, 1, p2, 32'h104);
    in_instr = p3; in_pc = 32'h108;
    tick();
    check_uop("pass3", PASS, 0, 0, 0, 0, 1, p3, 32'h108);
    in_valid = 1'b0;
    tick();
    check("pass.drain", 64'(out_valid), 64'd0);

    // PUSH n=3
    in_valid = 1'b1; in_instr = push3; in_pc = 32'h200;
    tick();
    check_uop("push.0", ADDI, 31, 31, 24'hFFFFE8, 0, 0, push3, 32'h200);
    in_valid = 1'b0;
    #1 check("push.0.in_ready", 64'(in_ready), 64'd0);
    tick();
    check_uop("push.1", STORE, 5, 31, 24'd0, 1, 0, push3, 32'h200);
    tick();
    check_uop("push.2", STORE, 6, 31, 24'd8, 2, 0, push3, 32'h200);
    tick();
    check_uop("push.3", STORE, 7, 31, 24'd16, 3, 1, push3, 32'h200);
    check("push.3.in_ready", 64'(in_ready), 64'd1);
    tick();
    check("push.drain", 64'(out_valid), 64'd0);

    // ENTER F=0x100 with out_ready toggling
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = enter; in_pc = 32'h300;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_uop($sformatf("enter.%0d", i), enter_exp[i].kind, enter_exp[i].rt, enter_exp[i].ra,
                enter_exp[i].imm, 3'(i), (i == 4), enter, 32'h300);
      tick();
      check_uop($sformatf("enter.%0d.stall", i), enter_exp[i].kind, enter_exp[i].rt,
                enter_exp[i].ra, enter_exp[i].imm, 3'(i), (i == 4), enter, 32'h300);
      out_ready = 1'b1;
      #1 check($sformatf("enter.%0d.in_ready", i), 64'(in_ready), 64'(i == 4));
      tick();
      out_ready = 1'b0;
    end
    check("enter.drain", 64'(out_valid), 64'd0);

    // LEAVE followed immediately by POP n=1
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = leave; in_pc = 32'h400;
    tick();
    check_uop("leave.0", ADDI, 31, 30, 24'd0, 0, 0, leave, 32'h400);
    in_instr = pop1; in_pc = 32'h404;
    #1 check("leave.0.in_ready", 64'(in_ready), 64'd0);
    tick();
    check_uop("leave.1", LOAD, 30, 31, 24'd0, 1, 0, leave, 32'h400);
    tick();
    check_uop("leave.2", LOAD, 29, 31, 24'd8, 2, 0, leave, 32'h400);
    tick();
    check_uop("leave.3", ADDI, 31, 31, 24'd16, 3, 1, leave, 32'h400);
    check("leave.3.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_uop("pop.0", LOAD, 3, 31, 24'd0, 0, 0, pop1, 32'h404);
    in_valid = 1'b0;
    tick();
    check_uop("pop.1", ADDI, 31, 31, 24'd8, 1, 1, pop1, 32'h404);
    tick();
    check("pop.drain", 64'(out_valid), 64'd0);

    // Flush during ENTER idx 2
    in_valid = 1'b1; in_instr = enter2; in_pc = 32'h500;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_uop("flush.enter.2", STORE, 29, 31, 24'd8, 2, 0, enter2, 32'h500);
    flush = 1'b1;
    in_valid = 1'b1; in_instr = p4; in_pc = 32'h600;
    #1 check("flush.in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.idx", 64'(out_idx), 64'd0);
    #1 check("flush.after.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_uop("flush.new", PASS, 0, 0, 0, 0, 1, p4, 32'h600);
    in_valid = 1'b0;
    tick();
    check("flush.drain", 64'(out_valid), 64'd0);

    // Asynchronous reset during PUSH idx 1
    in_valid = 1'b1; in_instr = push2; in_pc = 32'h700;
    tick();
    check_uop("rpush.0", ADDI, 31, 31, 24'hFFFFF0, 0, 0, push2, 32'h700);
    in_valid = 1'b0;
    tick();
    check_uop("rpush.1", STORE, 1, 31, 24'd0, 1, 0, push2, 32'h700);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    tick();
    rst_n = 1'b1;
    #1 check("midreset.in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_instr = p5; in_pc = 32'h800;
    tick();
    check_uop("midreset.pass", PASS, 0, 0, 0, 0, 1, p5, 32'h800);
    in_valid = 1'b0;
    tick();
    check("midreset.drain", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
